// File: rtl/cacheline_burst_adapter.sv
// Splits a cache-line write into a burst of memory beats and reassembles a read burst into a line.
// Latency: write BEATS+1 cycles, read BEATS+2 cycles to line_resp_o; each ready/rvalid stall adds one cycle.
module cacheline_burst_adapter #(
    parameter int LINE_W = 256,
    parameter int BEAT_W = 64,
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] line_addr_i,
    input  logic              line_read_i,
    input  logic              line_write_i,
    input  logic [LINE_W-1:0] line_wdata_i,
    output logic [LINE_W-1:0] line_rdata_o,
    output logic              line_resp_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic              mem_read_o,
    output logic              mem_write_o,
    output logic [BEAT_W-1:0] mem_wdata_o,
    input  logic              mem_ready_i,
    input  logic [BEAT_W-1:0] mem_rdata_i,
    input  logic              mem_rvalid_i
);
    localparam int BEATS = LINE_W / BEAT_W;
    localparam int CNT_W = $clog2(BEATS);
    localparam int OFF_W = $clog2(LINE_W / 8);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(BEATS - 1);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_WR     = 3'd1;
    localparam logic [2:0] S_RD_REQ = 3'd2;
    localparam logic [2:0] S_RD_COL = 3'd3;
    localparam logic [2:0] S_DONE   = 3'd4;

    logic [2:0]                   state_q, state_d;
    logic [CNT_W-1:0]             cnt_q, cnt_d;
    logic [ADDR_W-1:0]            addr_q, addr_d;
    logic [BEATS-1:0][BEAT_W-1:0] wline_q, wline_d;
    logic [BEATS-1:0][BEAT_W-1:0] rline_q, rline_d;
    logic [ADDR_W-1:0]            aligned_addr;

    // Offset bits are dropped by alignment; this keeps them visibly consumed.
    logic unused_offset;
    assign unused_offset = ^line_addr_i[OFF_W-1:0];
    assign aligned_addr  = {line_addr_i[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        wline_d = wline_q;
        rline_d = rline_q;
        case (state_q)
            S_IDLE: begin
                if (line_write_i) begin
                    addr_d  = aligned_addr;
                    wline_d = line_wdata_i;
                    cnt_d   = '0;
                    state_d = S_WR;
                end else if (line_read_i) begin
                    addr_d  = aligned_addr;
                    state_d = S_RD_REQ;
                end
            end
            S_WR: begin
                if (mem_ready_i) begin
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == LAST) state_d = S_DONE;
                end
            end
            S_RD_REQ: begin
                if (mem_ready_i) begin
                    cnt_d   = '0;
                    state_d = S_RD_COL;
                end
            end
            S_RD_COL: begin
                if (mem_rvalid_i) begin
                    rline_d[cnt_q] = mem_rdata_i;
                    cnt_d          = cnt_q + 1'b1;
                    if (cnt_q == LAST) state_d = S_DONE;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            wline_q <= '0;
            rline_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            wline_q <= wline_d;
            rline_q <= rline_d;
        end
    end

    // Outputs decode from registered state only, so no input reaches an output combinationally.
    assign mem_read_o   = (state_q == S_RD_REQ);
    assign mem_write_o  = (state_q == S_WR);
    assign line_resp_o  = (state_q == S_DONE);
    assign mem_addr_o   = addr_q;
    assign mem_wdata_o  = wline_q[cnt_q];
    assign line_rdata_o = rline_q;

endmodule
